// File: rtl/tug_referee.sv
// tug_referee: Tug-of-War round/match sequencer turning key presses into move pulses,
// round wins, scores and chain restart pulses.
module tug_referee #(
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_l,
    input  logic       key_r,
    input  logic       edge_l,
    input  logic       edge_r,
    output logic       L,
    output logic       R,
    output logic       playAgain,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic [1:0] winner,
    output logic       match_over
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [2:0] WS = 3'(WIN_SCORE);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {PLAY, HOLD, RESTART, DONE} state_t;

    state_t        state;
    logic          key_l_d, key_r_d;
    logic [CW-1:0] cnt;
    logic          press_l, press_r, valid_l, valid_r, win_l, win_r;
    logic [2:0]    next_l, next_r;

    always_comb begin
        press_l = key_l & ~key_l_d;
        press_r = key_r & ~key_r_d;
        valid_l = press_l & ~press_r;
        valid_r = press_r & ~press_l;
        win_l   = (state == PLAY) & valid_l & edge_l;
        win_r   = (state == PLAY) & valid_r & edge_r;
        next_l  = score_l + 3'd1;
        next_r  = score_r + 3'd1;
    end

    // The hold counter starts at HOLD_CYCLES-1 so HOLD lasts exactly HOLD_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PLAY;
            key_l_d    <= 1'b0;
            key_r_d    <= 1'b0;
            cnt        <= '0;
            L          <= 1'b0;
            R          <= 1'b0;
            playAgain  <= 1'b0;
            score_l    <= 3'd0;
            score_r    <= 3'd0;
            winner     <= 2'b00;
            match_over <= 1'b0;
        end else begin
            key_l_d   <= key_l;
            key_r_d   <= key_r;
            L         <= (state == PLAY) & valid_l & ~edge_l;
            R         <= (state == PLAY) & valid_r & ~edge_r;
            playAgain <= (state == HOLD) & (cnt == '0);
            case (state)
                PLAY: begin
                    cnt <= HOLD_LOAD;
                    if (win_l) begin
                        score_l    <= next_l;
                        winner     <= 2'b01;
                        match_over <= next_l == WS;
                        state      <= (next_l == WS) ? DONE : HOLD;
                    end else if (win_r) begin
                        score_r    <= next_r;
                        winner     <= 2'b10;
                        match_over <= next_r == WS;
                        state      <= (next_r == WS) ? DONE : HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state  <= RESTART;
                        winner <= 2'b00;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESTART: state <= PLAY;
                DONE:    state <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_tug_referee.sv
// tb_tug_referee: randomized and directed scoreboard bench against a cycle-timeline model.
module tb_tug_referee;
    localparam int WS = 7;
    localparam int HC = 4;

    logic       clk, reset, key_l, key_r, edge_l, edge_r;
    logic       L, R, playAgain, match_over;
    logic [2:0] score_l, score_r;
    logic [1:0] winner;

    tug_referee #(.WIN_SCORE(WS), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r),
        .edge_l(edge_l), .edge_r(edge_r), .L(L), .R(R), .playAgain(playAgain),
        .score_l(score_l), .score_r(score_r), .winner(winner), .match_over(match_over)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    logic [11:0] q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: round wins schedule the restart and resume cycles on an absolute timeline.
    int m_t = 0, restart_at = -1, resume_at = 0;
    int m_sl = 0, m_sr = 0;
    logic [1:0] m_win = 2'b00;
    logic m_over = 0, m_pl = 0, m_pr = 0;

    task automatic step(input logic rs, input logic kl, input logic kr, input logic el, input logic er);
        logic [11:0] e;
        logic vl, vr, act, el_o, er_o, pa;
        reset = rs; key_l = kl; key_r = kr; edge_l = el; edge_r = er;
        if (rs) begin
            m_sl = 0; m_sr = 0; m_win = 2'b00; m_over = 0; m_pl = 0; m_pr = 0;
            restart_at = -1; resume_at = 0;
            e = '0;
        end else begin
            vl = kl && !m_pl && !(kr && !m_pr);
            vr = kr && !m_pr && !(kl && !m_pl);
            act = !m_over && m_t >= resume_at;
            el_o = act && vl && !el;
            er_o = act && vr && !er;
            if (act && ((vl && el) || (vr && er))) begin
                if (vl) begin m_sl++; m_win = 2'b01; end
                else begin m_sr++; m_win = 2'b10; end
                if (m_sl == WS || m_sr == WS) m_over = 1;
                else begin restart_at = m_t + HC + 1; resume_at = m_t + HC + 2; end
            end
            pa = (m_t + 1 == restart_at);
            if (pa) m_win = 2'b00;
            e = {el_o, er_o, pa, 3'(m_sl), 3'(m_sr), m_win, m_over};
            m_pl = kl; m_pr = kr;
        end
        m_t++;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        logic [11:0] exp_v, act_v;
        cyc++;
        if (q.size() > 0) begin
            exp_v = q.pop_front();
            act_v = {L, R, playAgain, score_l, score_r, winner, match_over};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs cycle %0d: got L=%b R=%b pa=%b sl=%0d sr=%0d win=%b mo=%b, want L=%b R=%b pa=%b sl=%0d sr=%0d win=%b mo=%b",
                         cyc, act_v[11], act_v[10], act_v[9], act_v[8:6], act_v[5:3], act_v[2:1], act_v[0],
                         exp_v[11], exp_v[10], exp_v[9], exp_v[8:6], exp_v[5:3], exp_v[2:1], exp_v[0]);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; key_l = 0; key_r = 0; edge_l = 0; edge_r = 0;
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        idle(2);
        step(0, 1, 1, 0, 0); idle(2);
        step(0, 0, 1, 0, 0); idle(2);
        step(0, 0, 1, 0, 1); idle(2); step(0, 1, 0, 0, 0); idle(5);
        step(0, 1, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        idle(1); step(0, 1, 0, 0, 0); idle(2);
        step(0, 1, 0, 1, 0); idle(1); step(1, 0, 0, 0, 0); idle(8);
        step(0, 1, 0, 0, 0); idle(2);
        step(1, 0, 0, 0, 0);
        for (int w = 0; w < WS; w++) begin
            step(0, 1, 0, 1, 0);
            idle(HC + 2);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, i[0], 0); step(0, 0, 1, 0, i[1]);
        end
        idle(HC + 4);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4);
        idle(2);
        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
